// File: rtl/led_sched_pkg.sv
// Shared types for the LED stream scheduler.
//   state_t   : scheduler FSM states
//   pixel_t   : one 24-bit GRB/RGB pixel, bit 23 transmitted first
//   src_t     : index of a frame source (0 = host, 1 = pattern)
//   cnt_width : counter width helper, never returns less than 1
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  typedef logic [23:0] pixel_t;

  typedef logic src_t;

  // Bits needed to hold values 0..n-1; a 1-bit floor keeps degenerate
  // parameter choices from producing zero-width vectors.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_stream_scheduler_if.sv
// Bus bundle between the two frame sources and the LED stream scheduler.
//   i_req        : per-source frame request ([0]=host, [1]=pattern)
//   i_pix_valid  : per-source pixel valid
//   i_pix_data0/1: per-source pixel data
//   o_pix_ready  : per-source pixel accept
//   o_grant      : one-hot current owner
//   o_busy       : frame in progress
//   o_frame_done : pulse on the last latch cycle
//   o_underrun   : pulse when a frame is aborted for lack of pixels
//   o_serial     : encoded one-wire output
//   dbg_state    : scheduler FSM state, for observation only
//
// Pixel handshake: a pixel moves on a rising edge where both
// i_pix_valid[s] and o_pix_ready[s] are high. A source must hold valid
// and data stable until that edge; ready never depends on valid.
interface led_stream_scheduler_if;
  import led_sched_pkg::*;

  logic [1:0] i_req;
  logic [1:0] i_pix_valid;
  pixel_t     i_pix_data0;
  pixel_t     i_pix_data1;
  logic [1:0] o_pix_ready;
  logic [1:0] o_grant;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_underrun;
  logic       o_serial;
  state_t     dbg_state;

  modport master (
    output i_req, i_pix_valid, i_pix_data0, i_pix_data1,
    input  o_pix_ready, o_grant, o_busy, o_frame_done, o_underrun,
    input  o_serial, dbg_state
  );

  modport slave (
    input  i_req, i_pix_valid, i_pix_data0, i_pix_data1,
    output o_pix_ready, o_grant, o_busy, o_frame_done, o_underrun,
    output o_serial, dbg_state
  );

endinterface

// File: rtl/bit_encoder.sv
// One-wire bit encoder: turns one data bit into a BIT_CYCLES-long
// high/low pulse whose high time is T1H_CYCLES for a 1 and T0H_CYCLES
// for a 0.
//   clk, rst : clock and synchronous active-high reset
//   start    : begin a new bit this edge (only when idle or on bit_done)
//   bit_val  : value of the bit being sent, held stable for the whole bit
//   serial   : registered encoded output
//   bit_done : high during the last cycle of the current bit
module bit_encoder
  import led_sched_pkg::*;
#(
  parameter int BIT_CYCLES = 125,
  parameter int T0H_CYCLES = 40,
  parameter int T1H_CYCLES = 80
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic serial,
  output logic bit_done
);

  localparam int CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H_V = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_V = CW'(T1H_CYCLES);

  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_nx;
  logic [CW-1:0] high;
  logic          active;

  assign cyc_nx   = cyc + CW'(1);
  assign high     = bit_val ? T1H_V : T0H_V;
  assign bit_done = active && (cyc == LAST);

  // serial shows the level for cycle index cyc. Cycle 0 is high for
  // either bit value, so a start drives it high without looking at the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cyc    <= '0;
      serial <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cyc    <= '0;
      serial <= 1'b1;
    end else if (bit_done) begin
      active <= 1'b0;
      cyc    <= '0;
      serial <= 1'b0;
    end else if (active) begin
      cyc    <= cyc_nx;
      serial <= (cyc_nx < high);
    end
  end

endmodule

// File: rtl/led_stream_scheduler.sv
// LED stream scheduler: arbitrates two frame sources once per frame,
// streams NUM_LEDS pixels from the winner through the bit encoder and
// closes each frame with a LATCH_CYCLES low gap.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : source/status bundle (see led_stream_scheduler_if)
module led_stream_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int BIT_CYCLES   = 125,
  parameter int T0H_CYCLES   = 40,
  parameter int T1H_CYCLES   = 80,
  parameter int LATCH_CYCLES = 8000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  led_stream_scheduler_if.slave   bus
);

  localparam int PW = cnt_width(NUM_LEDS + 1);
  localparam int LW = cnt_width(LATCH_CYCLES);
  localparam logic [PW-1:0] NUM_V      = PW'(NUM_LEDS);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  src_t          gsel;       // granted source
  src_t          last_g;     // source granted most recently
  src_t          win;
  pixel_t        pix_in;
  pixel_t        shift_reg;
  pixel_t        hold_reg;
  logic          hold_full;
  logic [4:0]    bit_cnt;
  logic [PW-1:0] pix_cnt;    // pixels fully sent in this frame
  logic [PW-1:0] cap_cnt;    // pixels captured in this frame
  logic [LW-1:0] latch_cnt;
  logic [1:0]    ready;
  logic          accept;
  logic          pixel_end;
  logic          pix_last;
  logic          enc_start;
  logic          enc_done;
  logic          underrun;

  assign pix_in    = gsel ? bus.i_pix_data1 : bus.i_pix_data0;
  assign accept    = |(ready & bus.i_pix_valid);
  assign pixel_end = (state == SEND) && enc_done && (bit_cnt == 5'd0);
  assign pix_last  = ((pix_cnt + PW'(1)) == NUM_V);

  // Round robin: with both requesting, the source not granted last wins.
  always_comb begin
    win = bus.i_req[1];
    if (bus.i_req == 2'b11) win = ~last_g;
  end

  // Ready comes from state and registers only. It is also withheld in the
  // last cycle of a pixel with an empty holding register: that cycle
  // already commits to an underrun, so a late pixel must not be taken.
  always_comb begin
    ready = 2'b00;
    case (state)
      FETCH: ready[gsel] = 1'b1;
      SEND:  if (!hold_full && (cap_cnt != NUM_V) && !pixel_end) ready[gsel] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nx  = state;
    enc_start = 1'b0;
    underrun  = 1'b0;
    case (state)
      IDLE: if (|bus.i_req) state_nx = FETCH;
      FETCH: begin
        // A completed handshake wins over a request dropped in the same cycle.
        if (accept) begin
          state_nx  = SEND;
          enc_start = 1'b1;
        end else if (!bus.i_req[gsel]) begin
          state_nx = IDLE;
        end
      end
      SEND: begin
        if (enc_done) begin
          if (bit_cnt != 5'd0) begin
            enc_start = 1'b1;
          end else if (pix_last) begin
            state_nx = LATCH;
          end else if (hold_full) begin
            enc_start = 1'b1;
          end else begin
            underrun = 1'b1;
            state_nx = LATCH;
          end
        end
      end
      LATCH: if (latch_cnt == LATCH_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      gsel      <= 1'b0;
      last_g    <= 1'b1;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= 5'd0;
      pix_cnt   <= '0;
      cap_cnt   <= '0;
      latch_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (|bus.i_req) begin
            gsel      <= win;
            last_g    <= win;
            cap_cnt   <= '0;
            hold_full <= 1'b0;
          end
        end
        FETCH: begin
          if (accept) begin
            shift_reg <= pix_in;
            bit_cnt   <= 5'd23;
            pix_cnt   <= '0;
            cap_cnt   <= PW'(1);
          end
        end
        SEND: begin
          if (accept) begin
            hold_reg  <= pix_in;
            hold_full <= 1'b1;
            cap_cnt   <= cap_cnt + PW'(1);
          end
          if (enc_done) begin
            if (bit_cnt != 5'd0) begin
              bit_cnt   <= bit_cnt - 5'd1;
              shift_reg <= {shift_reg[22:0], 1'b0};
            end else begin
              pix_cnt <= pix_cnt + PW'(1);
              // Reload straight from the holding register: bit 23 of the
              // next pixel follows with no idle cycle.
              if (!pix_last && hold_full) begin
                shift_reg <= hold_reg;
                bit_cnt   <= 5'd23;
                hold_full <= 1'b0;
              end
            end
          end
          latch_cnt <= '0;
        end
        LATCH: latch_cnt <= latch_cnt + LW'(1);
        default: ;
      endcase
    end
  end

  bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_enc (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (enc_start),
    .bit_val  (shift_reg[23]),
    .serial   (bus.o_serial),
    .bit_done (enc_done)
  );

  assign bus.o_pix_ready  = ready;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_grant      = (state == IDLE) ? 2'b00 : (gsel ? 2'b10 : 2'b01);
  assign bus.o_frame_done = (state == LATCH) && (latch_cnt == LATCH_LAST);
  assign bus.o_underrun   = underrun;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_led_stream_scheduler.sv
// Directed bench for led_stream_scheduler with small timing parameters.
module tb_led_stream_scheduler;
  import led_sched_pkg::*;

  localparam int NUM_LEDS = 2;
  localparam int BIT_CYC  = 10;
  localparam int T0H      = 3;
  localparam int T1H      = 7;
  localparam int LATCH    = 20;

  logic clk;
  logic rst;
  led_stream_scheduler_if bus();

  led_stream_scheduler #(
    .NUM_LEDS     (NUM_LEDS),
    .BIT_CYCLES   (BIT_CYC),
    .T0H_CYCLES   (T0H),
    .T1H_CYCLES   (T1H),
    .LATCH_CYCLES (LATCH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int under_cnt = 0;
  pixel_t q0[$];
  pixel_t q1[$];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- pixel feeder ----------------
  // Handshake observed at the negedge (ready/valid are stable there),
  // queues advanced just after the following posedge.
  initial begin : feeder
    logic [1:0] hs;
    pixel_t dump;
    bus.i_pix_valid = 2'b00;
    bus.i_pix_data0 = '0;
    bus.i_pix_data1 = '0;
    forever begin
      @(negedge clk);
      hs = bus.i_pix_valid & bus.o_pix_ready;
      @(posedge clk);
      #1;
      if (hs[0] && q0.size() > 0) dump = q0.pop_front();
      if (hs[1] && q1.size() > 0) dump = q1.pop_front();
      bus.i_pix_valid[0] = (q0.size() != 0);
      bus.i_pix_valid[1] = (q1.size() != 0);
      bus.i_pix_data0    = (q0.size() != 0) ? q0[0] : '0;
      bus.i_pix_data1    = (q1.size() != 0) ? q1[0] : '0;
    end
  end

  // ---------------- pulse monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.o_frame_done === 1'b1) done_cnt++;
      if (bus.o_underrun === 1'b1) under_cnt++;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.dbg_state), 32'(s));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.o_frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.o_frame_done), 32'd1);
    @(negedge clk);
  endtask

  // Called at the negedge of cycle 0 of bit 23; returns at the negedge
  // following the pixel. Each bit's 10 serial samples are compared as one word.
  task automatic check_pixel(input pixel_t p, input string tag,
                             output int ur_total, output logic ur_last);
    logic [9:0] got;
    logic [9:0] exp;
    int hi;
    ur_total = 0;
    ur_last  = 1'b0;
    for (int b = 23; b >= 0; b--) begin
      hi = p[b] ? T1H : T0H;
      for (int k = 0; k < BIT_CYC; k++) begin
        got[k] = bus.o_serial;
        exp[k] = (k < hi);
        ur_last = bus.o_underrun;
        if (bus.o_underrun === 1'b1) ur_total++;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d", tag, b), 32'(got), 32'(exp));
    end
  endtask

  task automatic check_latch(input string tag);
    logic [LATCH-1:0] ser;
    logic [LATCH-1:0] dn;
    for (int k = 0; k < LATCH; k++) begin
      ser[k] = bus.o_serial;
      dn[k]  = bus.o_frame_done;
      @(negedge clk);
    end
    check({tag, " latch serial"}, 32'(ser), 32'd0);
    check({tag, " done position"}, 32'(dn), 32'h80000);
    check({tag, " idle state"}, 32'(bus.dbg_state), 32'(IDLE));
    check({tag, " grant released"}, 32'(bus.o_grant), 32'd0);
    check({tag, " busy cleared"}, 32'(bus.o_busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int ur_t;
    logic ur_l;
    rst = 1'b1;
    bus.i_req = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst state", 32'(bus.dbg_state), 32'(IDLE));
    check("rst serial", 32'(bus.o_serial), 32'd0);
    check("rst grant", 32'(bus.o_grant), 32'd0);
    check("rst busy", 32'(bus.o_busy), 32'd0);
    check("rst ready", 32'(bus.o_pix_ready), 32'd0);
    check("rst done", 32'(bus.o_frame_done), 32'd0);
    check("rst underrun", 32'(bus.o_underrun), 32'd0);
    rst = 1'b0;

    // Frame 1: source 0, 0xFF0000 then 0x000001, no gaps
    q0.push_back(24'hFF0000);
    q0.push_back(24'h000001);
    bus.i_req = 2'b01;
    @(negedge clk);
    check("f1 fetch state", 32'(bus.dbg_state), 32'(FETCH));
    check("f1 grant", 32'(bus.o_grant), 32'd1);
    check("f1 busy", 32'(bus.o_busy), 32'd1);
    check("f1 fetch ready", 32'(bus.o_pix_ready), 32'd1);
    wait_state(SEND, 20, "f1 reach send");
    bus.i_req = 2'b00;
    check("f1 first high", 32'(bus.o_serial), 32'd1);
    check_pixel(24'hFF0000, "f1 px0", ur_t, ur_l);
    check_pixel(24'h000001, "f1 px1", ur_t, ur_l);
    check("f1 no underrun", 32'(ur_t), 32'd0);
    check_latch("f1");
    #1;
    check("f1 done count", 32'(done_cnt), 32'd1);
    check("f1 underrun count", 32'(under_cnt), 32'd0);

    // Arbitration: both request after reset -> 0, then 1, then 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q0.push_back(24'h111111); q0.push_back(24'h222222);
    q0.push_back(24'h333333); q0.push_back(24'h444444);
    q1.push_back(24'h555555); q1.push_back(24'h666666);
    bus.i_req = 2'b11;
    @(negedge clk);
    check("arb first grant", 32'(bus.o_grant), 32'd1);
    wait_done(1000, "arb frame a done");
    check("arb gap idle", 32'(bus.dbg_state), 32'(IDLE));
    check("arb gap grant", 32'(bus.o_grant), 32'd0);
    @(negedge clk);
    check("arb second grant", 32'(bus.o_grant), 32'd2);
    wait_done(1000, "arb frame b done");
    check("arb gap2 idle", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    check("arb third grant", 32'(bus.o_grant), 32'd1);
    wait_state(SEND, 20, "arb c send");
    bus.i_req = 2'b00;
    wait_done(1000, "arb frame c done");
    #1;
    check("arb done count", 32'(done_cnt), 32'd4);
    check("arb queues drained", 32'(q0.size() + q1.size()), 32'd0);

    // Underrun: source 1 supplies only one pixel
    @(negedge clk);
    q1.push_back(24'hA5A5A5);
    bus.i_req = 2'b10;
    @(negedge clk);
    check("ur grant", 32'(bus.o_grant), 32'd2);
    wait_state(SEND, 20, "ur reach send");
    bus.i_req = 2'b00;
    check_pixel(24'hA5A5A5, "ur px0", ur_t, ur_l);
    check("ur pulse at bit0 end", 32'(ur_l), 32'd1);
    check("ur pulse width", 32'(ur_t), 32'd1);
    check_latch("ur");
    #1;
    check("ur done count", 32'(done_cnt), 32'd5);
    check("ur underrun count", 32'(under_cnt), 32'd1);

    // Request dropped in FETCH with no valid
    @(negedge clk);
    bus.i_req = 2'b01;
    @(negedge clk);
    check("drop fetch state", 32'(bus.dbg_state), 32'(FETCH));
    check("drop fetch grant", 32'(bus.o_grant), 32'd1);
    repeat (3) @(negedge clk);
    check("drop fetch serial", 32'(bus.o_serial), 32'd0);
    bus.i_req = 2'b00;
    @(negedge clk);
    check("drop idle state", 32'(bus.dbg_state), 32'(IDLE));
    check("drop grant", 32'(bus.o_grant), 32'd0);
    check("drop serial", 32'(bus.o_serial), 32'd0);
    #1;
    check("drop no pulses", 32'(done_cnt * 16 + under_cnt), 32'(5 * 16 + 1));

    // Reset during a high phase of the first bit
    @(negedge clk);
    q0.push_back(24'hFFFFFF);
    q0.push_back(24'h123456);
    bus.i_req = 2'b01;
    wait_state(SEND, 20, "mid rst send");
    check("mid rst high phase", 32'(bus.o_serial), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst serial", 32'(bus.o_serial), 32'd0);
    check("mid rst grant", 32'(bus.o_grant), 32'd0);
    check("mid rst busy", 32'(bus.o_busy), 32'd0);
    check("mid rst state", 32'(bus.dbg_state), 32'(IDLE));
    rst = 1'b0;
    q0.delete();
    q0.push_back(24'h0F0F0F);
    q0.push_back(24'hF0F0F0);
    wait_state(SEND, 20, "post rst send");
    bus.i_req = 2'b00;
    check_pixel(24'h0F0F0F, "post rst px0", ur_t, ur_l);
    check_pixel(24'hF0F0F0, "post rst px1", ur_t, ur_l);
    check_latch("post rst");
    #1;
    check("post rst done count", 32'(done_cnt), 32'd6);
    check("post rst underrun count", 32'(under_cnt), 32'd1);

    // Three pixels queued: exactly two accepted
    @(negedge clk);
    q0.push_back(24'h3C00C3);
    q0.push_back(24'h81FF18);
    q0.push_back(24'h555555);
    bus.i_req = 2'b01;
    wait_state(SEND, 20, "extra send");
    bus.i_req = 2'b00;
    check_pixel(24'h3C00C3, "extra px0", ur_t, ur_l);
    check("extra ready low", 32'(bus.o_pix_ready), 32'd0);
    check("extra valid held", 32'(bus.i_pix_valid[0]), 32'd1);
    check_pixel(24'h81FF18, "extra px1", ur_t, ur_l);
    check_latch("extra");
    check("extra pending count", 32'(q0.size()), 32'd1);
    check("extra pending pixel", 32'(q0[0]), 32'h555555);
    #1;
    check("extra done count", 32'(done_cnt), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
